// File: rtl/dma_block_controller.sv
// dma_block_controller
//   Block DMA engine that copies 16-bit device words into data memory. The CPU
//   issues a command (start address, word count); the block requests the bus
//   with BR, and once BG is returned it drives the data-memory write port
//   itself. The CPU is interrupted by a one-cycle dma_done pulse at the end.
//
// Build option:
//   DMA_CYCLE_STEAL_EN - after BURST_LEN completed writes in one bus tenure,
//   with words still remaining, BR drops for exactly one cycle so the CPU can
//   use the bus. The BURST_LEN parameter only exists in that build.
//
// Ports:
//   Clk, Reset_N        clock (posedge) and synchronous active-low reset
//   cmd_valid_i/addr/len  command strobe, first word address, word count
//   cmd_ready_o         high only while idle
//   BR_o, BG_i          bus request / bus grant handshake with the CPU
//   dev_data_i/valid_i  device word and its valid flag
//   dev_ready_o         one-cycle pulse: current device word consumed
//   m_writeM_o          write strobe, held until m_doneM_i
//   m_address_o/data_o  write address and data (muxed onto the bus at top level)
//   m_doneM_i           memory write complete
//   busy_o              a command is in progress
//   dma_done_o          one-cycle completion pulse
module dma_block_controller #(
    parameter int unsigned LEN_W = 8
`ifdef DMA_CYCLE_STEAL_EN
    ,
    parameter int unsigned BURST_LEN = 4
`endif
) (
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             cmd_valid_i,
    input  logic [15:0]      cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    output logic             cmd_ready_o,
    output logic             BR_o,
    input  logic             BG_i,
    input  logic [15:0]      dev_data_i,
    input  logic             dev_valid_i,
    output logic             dev_ready_o,
    output logic             m_writeM_o,
    output logic [15:0]      m_address_o,
    output logic [15:0]      m_data_o,
    input  logic             m_doneM_i,
    output logic             busy_o,
    output logic             dma_done_o
);

    // StGap is the one-cycle bus release of the cycle-steal build.
    typedef enum logic [2:0] {StIdle, StReq, StXfer, StWait, StRel, StGap} state_e;

    state_e           state_q;
    logic [15:0]      addr_q, addr_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic             br_q, wr_q, dev_ready_q, done_q;
    logic [15:0]      m_address_q, m_data_q;

`ifdef DMA_CYCLE_STEAL_EN
    localparam int unsigned BurstW = $clog2(BURST_LEN + 1);
    logic [BurstW-1:0] burst_q, burst_d;
`endif

    // addr wraps modulo 2^16; remain_d is only consumed in StWait where remain_q >= 1.
    always_comb begin
        addr_d   = addr_q + 16'd1;
        remain_d = remain_q - LEN_W'(1);
`ifdef DMA_CYCLE_STEAL_EN
        burst_d  = burst_q + BurstW'(1);
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remain_q    <= '0;
            br_q        <= 1'b0;
            wr_q        <= 1'b0;
            dev_ready_q <= 1'b0;
            done_q      <= 1'b0;
            m_address_q <= '0;
            m_data_q    <= '0;
`ifdef DMA_CYCLE_STEAL_EN
            burst_q     <= '0;
`endif
        end else begin
            dev_ready_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        addr_q   <= cmd_addr_i;
                        remain_q <= cmd_len_i;
                        // Empty block completes at once without touching the bus.
                        if (cmd_len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StReq;
                            br_q    <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (BG_i) begin
                        state_q <= StXfer;
`ifdef DMA_CYCLE_STEAL_EN
                        burst_q <= '0;
`endif
                    end
                end
                StXfer: begin
                    // Grant lost before a write started: ask again, nothing in flight.
                    if (!BG_i) begin
                        state_q <= StReq;
                    end else if (dev_valid_i) begin
                        m_address_q <= addr_q;
                        m_data_q    <= dev_data_i;
                        wr_q        <= 1'b1;
                        dev_ready_q <= 1'b1;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    // The in-flight write always finishes, even if BG has dropped.
                    if (m_doneM_i) begin
                        wr_q     <= 1'b0;
                        addr_q   <= addr_d;
                        remain_q <= remain_d;
`ifdef DMA_CYCLE_STEAL_EN
                        burst_q  <= burst_d;
`endif
                        if (remain_d == '0) begin
                            state_q <= StRel;
                            br_q    <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (!BG_i) begin
                            state_q <= StReq;
`ifdef DMA_CYCLE_STEAL_EN
                        end else if (burst_d == BurstW'(BURST_LEN)) begin
                            state_q <= StGap;
                            br_q    <= 1'b0;
`endif
                        end else begin
                            state_q <= StXfer;
                        end
                    end
                end
                StRel: begin
                    state_q <= StIdle;
                end
                StGap: begin
                    state_q <= StReq;
                    br_q    <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    br_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign BR_o        = br_q;
    assign dev_ready_o = dev_ready_q;
    assign m_writeM_o  = wr_q;
    assign m_address_o = m_address_q;
    assign m_data_o    = m_data_q;
    assign dma_done_o  = done_q;

endmodule
